wb_ram_slave: RTL

WB_RAM_SLAVE -- requirements
Module: wb_ram_slave

---
 rtl/wb_ram_slave.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_ram_slave.sv
// wb_ram_slave: Wishbone classic-cycle RAM responder with optional wait states.
// Holds 2**ADDR_WIDTH 32-bit words starting at byte address BASE_ADDR.
//
// Parameters:
//   ADDR_WIDTH   log2 of the number of 32-bit words (default 10)
//   BASE_ADDR    byte address of word 0 (default 32'h0000_0000)
//   WAIT_CYCLES  extra wait states per access, 0..15 (default 0)
//
// Ports:
//   clk_i       clock, all state on the rising edge
//   rst_i       synchronous active-high reset
//   wbs_cyc_i   bus cycle active
//   wbs_stb_i   strobe, request valid
//   wbs_we_i    1 = write, 0 = read
//   wbs_sel_i   byte lane enables, bit n covers dat[8n+7:8n]
//   wbs_addr_i  byte address, bits [1:0] ignored
//   wbs_dat_i   write data
//   wbs_dat_o   read data, zero whenever wbs_ack_o is low
//   wbs_ack_o   normal termination, one-cycle pulse
//   wbs_err_o   error termination, one-cycle pulse
//
// Build option:
//   WB_RAM_SLAVE_ADDR_ERR_EN  when defined, addresses outside the array
//   window terminate with wbs_err_o (no write, zero data). When undefined,
//   wbs_err_o is tied low and out-of-range addresses wrap onto the array.

module wb_ram_slave #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_addr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Counter is loaded with WAIT_CYCLES-1 so that WAIT lasts exactly
    // WAIT_CYCLES cycles before RESP.
    localparam logic [3:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;

    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] addr_q;
    logic [31:0] dat_q;

    logic        ack_q;
    logic [31:0] rdat_q;

    logic [31:0] mem [0:DEPTH-1];

    // Access attributes used at the edge entering RESP. With no wait
    // states that edge is the request edge itself, so the live bus
    // inputs are used; otherwise the values captured on request.
    logic        req;
    logic        acc_we;
    logic [3:0]  acc_sel;
    logic [31:0] acc_addr;
    logic [31:0] acc_dat;
    logic [31:0] acc_off;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic        acc_ok;
    logic        enter_resp;
    logic        do_write;

    always_comb begin
        req = wbs_cyc_i & wbs_stb_i;

        acc_we   = we_q;
        acc_sel  = sel_q;
        acc_addr = addr_q;
        acc_dat  = dat_q;
        if (state == IDLE) begin
            acc_we   = wbs_we_i;
            acc_sel  = wbs_sel_i;
            acc_addr = wbs_addr_i;
            acc_dat  = wbs_dat_i;
        end

        acc_off = acc_addr - BASE_ADDR;
        acc_idx = acc_off[ADDR_WIDTH+1:2];
    end

`ifdef WB_RAM_SLAVE_ADDR_ERR_EN
    // In range when the offset from BASE_ADDR is below the window size;
    // addresses below BASE_ADDR wrap to huge offsets and fail as well.
    assign acc_ok = ((acc_off >> (ADDR_WIDTH + 2)) == 32'd0);
`else
    assign acc_ok = 1'b1;
`endif

    // Offset bits that never select a word; kept in one sink signal.
    logic unused_off;
    assign unused_off = ^{acc_off[1:0], acc_off[31:ADDR_WIDTH+2]};

    always_comb begin
        enter_resp = 1'b0;
        unique case (state)
            IDLE:    enter_resp = req && (WAIT_CYCLES == 0);
            WAIT:    enter_resp = wbs_cyc_i && (cnt == 4'd0);
            default: enter_resp = 1'b0;
        endcase
        // Reset wins over a completing access.
        if (rst_i) begin
            enter_resp = 1'b0;
        end
        do_write = enter_resp & acc_we & acc_ok;
    end

    // Memory has no reset; contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_sel[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_dat[8*b +: 8];
                end
            end
        end
    end

`ifdef WB_RAM_SLAVE_ADDR_ERR_EN
    logic err_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            ack_q  <= 1'b0;
            rdat_q <= 32'd0;
`ifdef WB_RAM_SLAVE_ADDR_ERR_EN
            err_q  <= 1'b0;
`endif
        end else begin
            // Responses are single-cycle pulses by default.
            ack_q  <= 1'b0;
            rdat_q <= 32'd0;
`ifdef WB_RAM_SLAVE_ADDR_ERR_EN
            err_q  <= 1'b0;
`endif

            unique case (state)
                IDLE: begin
                    if (req) begin
                        we_q   <= wbs_we_i;
                        sel_q  <= wbs_sel_i;
                        addr_q <= wbs_addr_i;
                        dat_q  <= wbs_dat_i;
                        if (WAIT_CYCLES > 0) begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    // Only cyc low aborts; a dropped stb does not.
                    if (!wbs_cyc_i) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase

            if (enter_resp) begin
                ack_q <= acc_ok;
`ifdef WB_RAM_SLAVE_ADDR_ERR_EN
                err_q <= ~acc_ok;
`endif
                if (!acc_we && acc_ok) begin
                    rdat_q <= mem[acc_idx];
                end
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdat_q;

`ifdef WB_RAM_SLAVE_ADDR_ERR_EN
    assign wbs_err_o = err_q;
`else
    assign wbs_err_o = 1'b0;
`endif

endmodule
